cache_dir_ctrl: RTL
===================

Name: cache_dir_ctrl

Overview:
Per-port lookup and miss-handling controller that sits directly upstream of cache_directory and drives one of its directory ports (index/next_tag/next_state/write in, current_tag/current_state out). It accepts one core request at a time and splits the address into tag, index and offset. It reads the directory, classifies hit, miss or upgrade, and issues writeback and refill transactions to the memory side. It writes the new tag/state back into the directory and then returns a response to the core.

Parameters:
ADDR_WIDTH, 32, request address width
INDEX_WIDTH, 7, directory index width; must match cache_directory
TAG_WIDTH, 20, tag width; OFFSET_WIDTH = ADDR_WIDTH-INDEX_WIDTH-TAG_WIDTH (5 by default)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_WIDTH  request byte address
req_store  in  1  1=store (needs write permission), 0=load
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_hit  out  1  1 if the line was present on first lookup (including upgrade)
dir_index  out  INDEX_WIDTH  to directory port index
dir_next_tag  out  TAG_WIDTH  to directory next_tag
dir_next_state  out  $bits(line_state_t)  to directory next_state
dir_write  out  1  to directory write
dir_current_tag  in  TAG_WIDTH  from directory current_tag
dir_current_state  in  $bits(line_state_t)  from directory current_state
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_op  out  $bits(mem_op_t)  MEM_READ_SHARED / MEM_READ_EXCL / MEM_WRITEBACK
mem_req_addr  out  ADDR_WIDTH  line-aligned address, offset bits zero
mem_rsp_valid  in  1  refill complete (single-cycle pulse)
mem_rsp_excl  in  1  refill granted exclusive; sampled with mem_rsp_valid

Behaviour:
- Reset (rst=0, async): FSM returns to IDLE. All outputs are 0, except req_ready, which is 1 (IDLE).
- Directory read latency is 1 cycle. current_* reflects the dir_index driven in the previous cycle. A dir_write takes effect at the clock edge where it is high.
- States: IDLE, LOOKUP, COMPARE, WB_REQ, FILL_REQ, FILL_WAIT, UPDATE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register addr/store, go to LOOKUP. The core must hold req_* stable only until the handshake.
- LOOKUP: drive dir_index from the registered index, go to COMPARE. dir_index stays held from LOOKUP through UPDATE.
- COMPARE: hit = state!=INVALID && current_tag==req tag.
  - Load hit: no write, rsp_hit=1, go to RESP.
  - Store hit on EXCLUSIVE/MODIFIED: dir_write=1 this cycle, next_tag=current tag, next_state=MODIFIED, rsp_hit=1, go to RESP.
  - Store hit on SHARED (upgrade): rsp_hit=1, go to FILL_REQ; no writeback.
  - Miss with victim MODIFIED: capture victim tag, go to WB_REQ.
  - Miss otherwise: rsp_hit=0, go to FILL_REQ.
- WB_REQ: mem_req_valid=1, op=MEM_WRITEBACK, addr={victim tag, index, 0}. On mem_req_ready go to FILL_REQ. Writeback is posted; no response is expected.
- FILL_REQ: mem_req_valid=1, op = req_store ? MEM_READ_EXCL : MEM_READ_SHARED, addr={req tag, index, 0}. On mem_req_ready go to FILL_WAIT.
- Valid/ready rules: mem_req_valid and payload are held stable until mem_req_ready. Once asserted, valid is never withdrawn.
- FILL_WAIT: wait for mem_rsp_valid; capture mem_rsp_excl; go to UPDATE. A mem_rsp_valid seen in any other state is ignored.
- UPDATE: dir_write=1 for exactly one cycle, next_tag=req tag. next_state = store ? MODIFIED : (excl ? EXCLUSIVE : SHARED). Go to RESP.
- RESP: rsp_valid=1 and rsp_hit held until rsp_ready, then go to IDLE. The next request can be accepted one cycle after the response handshake.
- Latencies (accept at cycle T):
  - Hit: rsp_valid at T+3.
  - Miss: RESP two cycles after mem_rsp_valid.
- dir_write is 0 in every state except COMPARE (store hit E/M) and UPDATE.
- dir_next_tag and dir_next_state are 0 when dir_write=0.
- Reset asserted mid-transaction abandons it with no directory write; the memory side must tolerate the dropped request.

Decomposition:
- cache_pkg:
  - line_state_t, existing: INVALID=0, SHARED, EXCLUSIVE, MODIFIED.
  - New mem_op_t: MEM_READ_SHARED=0, MEM_READ_EXCL=1, MEM_WRITEBACK=2.
  - New ctrl_state_t enum for the FSM.
  - Helper functions addr_tag(), addr_index() and line_addr().
- No sub-module. The FSM plus request/victim registers form a single module, instantiated once per cache_directory port.

Test Plan:
- Load hit: pre-seed directory index 0x11 = {tag 0x00001, SHARED}, load 0x0000_1234 -> no mem_req; rsp_valid at T+3, rsp_hit=1; no dir_write.
- Load miss, clean victim: index 0x11 INVALID, load 0x0000_1234 -> FILL_REQ op=READ_SHARED addr 0x0000_1220. mem_rsp with excl=1 -> UPDATE writes tag 0x00001, EXCLUSIVE; rsp_hit=0.
- Store miss, dirty victim: index 0x11 = {0x00ABC, MODIFIED}, store 0x0000_1234 -> WRITEBACK addr 0x00AB_C220, then READ_EXCL addr 0x0000_1220. Directory ends {0x00001, MODIFIED}.
- Store upgrade: index 0x11 = {0x00001, SHARED}, store 0x0000_1234 -> no writeback; READ_EXCL issued; final MODIFIED; rsp_hit=1.
- Backpressure: mem_req_ready=0 for 5 cycles, then rsp_ready=0 for 3 cycles -> mem_req_* and rsp_* stay stable; exactly one handshake each.
- Reset in FILL_WAIT: drop rst for 1 cycle -> all outputs 0, req_ready=1 after release; no dir_write; a later load to the same index misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the cache directory and its per-port
// lookup / miss-handling controllers.
package cache_pkg;

    // Coherence state stored per directory line.
    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } line_state_t;

    // Memory-side transaction kinds.
    typedef enum logic [1:0] {
        MEM_READ_SHARED = 2'd0,
        MEM_READ_EXCL   = 2'd1,
        MEM_WRITEBACK   = 2'd2
    } mem_op_t;

    // Controller FSM states.
    typedef enum logic [2:0] {
        CS_IDLE      = 3'd0,
        CS_LOOKUP    = 3'd1,
        CS_COMPARE   = 3'd2,
        CS_WB_REQ    = 3'd3,
        CS_FILL_REQ  = 3'd4,
        CS_FILL_WAIT = 3'd5,
        CS_UPDATE    = 3'd6,
        CS_RESP      = 3'd7
    } ctrl_state_t;

    localparam int unsigned LINE_STATE_W = $bits(line_state_t);
    localparam int unsigned MEM_OP_W     = $bits(mem_op_t);

    // Helpers work on a wide container so any ADDR_WIDTH up to 64 fits;
    // callers size-cast the result to their own field width.
    localparam int unsigned WIDE_ADDR_W = 64;
    typedef logic [WIDE_ADDR_W-1:0] wide_addr_t;

    // Tag field: everything above index and offset.
    function automatic wide_addr_t addr_tag(input wide_addr_t addr,
                                            input int unsigned off_w,
                                            input int unsigned idx_w);
        return addr >> (off_w + idx_w);
    endfunction

    // Index field: idx_w bits directly above the line offset.
    function automatic wide_addr_t addr_index(input wide_addr_t addr,
                                              input int unsigned off_w,
                                              input int unsigned idx_w);
        wide_addr_t mask;
        mask = (wide_addr_t'(1) << idx_w) - wide_addr_t'(1);
        return (addr >> off_w) & mask;
    endfunction

    // Line-aligned address rebuilt from tag and index, offset bits zero.
    function automatic wide_addr_t line_addr(input wide_addr_t tag,
                                             input wide_addr_t index,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
        return (tag << (off_w + idx_w)) | (index << off_w);
    endfunction

endpackage

// File: rtl/cache_dir_ctrl.sv
// Per-port directory controller: accepts one core request, looks it up in
// cache_directory, resolves hit / upgrade / miss (with optional writeback of a
// dirty victim), writes the new tag/state and answers the core.
module cache_dir_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 7,
    parameter int unsigned TAG_WIDTH   = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    // core request / response
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_store,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_hit,
    // directory port
    output logic [INDEX_WIDTH-1:0]  dir_index,
    output logic [TAG_WIDTH-1:0]    dir_next_tag,
    output logic [LINE_STATE_W-1:0] dir_next_state,
    output logic                    dir_write,
    input  logic [TAG_WIDTH-1:0]    dir_current_tag,
    input  logic [LINE_STATE_W-1:0] dir_current_state,
    // memory side
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [MEM_OP_W-1:0]     mem_req_op,
    output logic [ADDR_WIDTH-1:0]   mem_req_addr,
    input  logic                    mem_rsp_valid,
    input  logic                    mem_rsp_excl
);

    localparam int unsigned OFFSET_WIDTH = ADDR_WIDTH - INDEX_WIDTH - TAG_WIDTH;

    ctrl_state_t             r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_store;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic                    r_rsp_hit;
    logic [INDEX_WIDTH-1:0]  r_dir_index;
    logic                    r_mem_req_valid;
    mem_op_t                 r_mem_req_op;
    logic [ADDR_WIDTH-1:0]   r_mem_req_addr;
    logic                    r_upd_write;
    logic [TAG_WIDTH-1:0]    r_upd_tag;
    line_state_t             r_upd_state;

    logic [TAG_WIDTH-1:0]    w_req_tag;
    logic [INDEX_WIDTH-1:0]  w_req_index;
    logic [INDEX_WIDTH-1:0]  w_in_index;
    line_state_t             w_cur_state;
    logic                    w_hit;
    logic                    w_cmp_write;
    mem_op_t                 w_fill_op;
    logic [ADDR_WIDTH-1:0]   w_fill_addr;
    logic [ADDR_WIDTH-1:0]   w_wb_addr;

    // Address fields of the registered request and of the incoming one.
    assign w_req_tag   = TAG_WIDTH'(addr_tag(wide_addr_t'(r_addr), OFFSET_WIDTH, INDEX_WIDTH));
    assign w_req_index = INDEX_WIDTH'(addr_index(wide_addr_t'(r_addr), OFFSET_WIDTH, INDEX_WIDTH));
    assign w_in_index  = INDEX_WIDTH'(addr_index(wide_addr_t'(req_addr), OFFSET_WIDTH, INDEX_WIDTH));

    // Lookup classification; only meaningful in COMPARE, one cycle after LOOKUP.
    assign w_cur_state = line_state_t'(dir_current_state);
    assign w_hit       = (w_cur_state != INVALID) && (dir_current_tag == w_req_tag);
    assign w_cmp_write = (r_state == CS_COMPARE) && r_store && w_hit &&
                         ((w_cur_state == EXCLUSIVE) || (w_cur_state == MODIFIED));

    // Memory transactions: refill of the requested line, writeback of the victim.
    assign w_fill_op   = r_store ? MEM_READ_EXCL : MEM_READ_SHARED;
    assign w_fill_addr = ADDR_WIDTH'(line_addr(wide_addr_t'(w_req_tag), wide_addr_t'(w_req_index),
                                               OFFSET_WIDTH, INDEX_WIDTH));
    assign w_wb_addr   = ADDR_WIDTH'(line_addr(wide_addr_t'(dir_current_tag), wide_addr_t'(w_req_index),
                                               OFFSET_WIDTH, INDEX_WIDTH));

    // Controller FSM; every handshake-facing output is a register set on the
    // transition into the state that owns it.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments so every branch sees pre-edge register values.
        if (!rst) begin
            r_state         <= CS_IDLE;
            r_addr          <= '0;
            r_store         <= 1'b0;
            r_req_ready     <= 1'b1;
            r_rsp_valid     <= 1'b0;
            r_rsp_hit       <= 1'b0;
            r_dir_index     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_op    <= MEM_READ_SHARED;
            r_mem_req_addr  <= '0;
            r_upd_write     <= 1'b0;
            r_upd_tag       <= '0;
            r_upd_state     <= INVALID;
        end else begin
            case (r_state)
                CS_IDLE: begin
                    if (req_valid) begin
                        r_addr      <= req_addr;
                        r_store     <= req_store;
                        r_dir_index <= w_in_index;
                        r_req_ready <= 1'b0;
                        r_state     <= CS_LOOKUP;
                    end
                end
                CS_LOOKUP: begin
                    r_state <= CS_COMPARE;
                end
                CS_COMPARE: begin
                    if (w_hit && (!r_store || w_cur_state != SHARED)) begin
                        // load hit, or store hit with write permission already held
                        r_rsp_hit   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= CS_RESP;
                    end else if (w_hit) begin
                        // store to a SHARED line: upgrade, nothing to write back
                        r_rsp_hit       <= 1'b1;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_op    <= w_fill_op;
                        r_mem_req_addr  <= w_fill_addr;
                        r_state         <= CS_FILL_REQ;
                    end else if (w_cur_state == MODIFIED) begin
                        // dirty victim: the writeback address captures its tag
                        r_rsp_hit       <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_op    <= MEM_WRITEBACK;
                        r_mem_req_addr  <= w_wb_addr;
                        r_state         <= CS_WB_REQ;
                    end else begin
                        r_rsp_hit       <= 1'b0;
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_op    <= w_fill_op;
                        r_mem_req_addr  <= w_fill_addr;
                        r_state         <= CS_FILL_REQ;
                    end
                end
                CS_WB_REQ: begin
                    // writeback is posted; the refill request follows back-to-back
                    if (mem_req_ready) begin
                        r_mem_req_op   <= w_fill_op;
                        r_mem_req_addr <= w_fill_addr;
                        r_state        <= CS_FILL_REQ;
                    end
                end
                CS_FILL_REQ: begin
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_mem_req_op    <= MEM_READ_SHARED;
                        r_mem_req_addr  <= '0;
                        r_state         <= CS_FILL_WAIT;
                    end
                end
                CS_FILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_upd_write <= 1'b1;
                        r_upd_tag   <= w_req_tag;
                        r_upd_state <= r_store      ? MODIFIED  :
                                       mem_rsp_excl ? EXCLUSIVE : SHARED;
                        r_state     <= CS_UPDATE;
                    end
                end
                CS_UPDATE: begin
                    r_upd_write <= 1'b0;
                    r_upd_tag   <= '0;
                    r_upd_state <= INVALID;
                    r_rsp_valid <= 1'b1;
                    r_state     <= CS_RESP;
                end
                CS_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_hit   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= CS_IDLE;
                    end
                end
                default: begin
                    r_state <= CS_IDLE;
                end
            endcase
        end
    end

    // Directory write port: the COMPARE store-hit write depends on the lookup
    // result of the same cycle, the UPDATE write comes from registers.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        dir_write      = 1'b0;
        dir_next_tag   = '0;
        dir_next_state = '0;
        if (w_cmp_write) begin
            dir_write      = 1'b1;
            dir_next_tag   = dir_current_tag;
            dir_next_state = MODIFIED;
        end else if (r_upd_write) begin
            dir_write      = 1'b1;
            dir_next_tag   = r_upd_tag;
            dir_next_state = r_upd_state;
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_hit       = r_rsp_hit;
    assign dir_index     = r_dir_index;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_op    = r_mem_req_op;
    assign mem_req_addr  = r_mem_req_addr;

endmodule
